// File: rtl/fc_layer_stream.sv
// fc_layer_stream: fully-connected layer with streaming input and output.
// The layer loads N_IN activations into a pixel RAM. It then computes N_OUT
// neurons with N_MAC parallel MAC lanes over P = N_OUT/N_MAC passes, reading
// weights and biases from an external memory. Results are streamed out
// through a valid/ready handshake.
// Optional feature: define FC_RELU_EN to clamp negative results to zero.
module fc_layer_stream #(
    parameter int BITS     = 24,
    parameter int FRAC     = 12,
    parameter int N_IN     = 784,
    parameter int N_OUT    = 10,
    parameter int N_MAC    = 10,
    parameter int ACC_BITS = 2*BITS + $clog2(N_IN+1)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [BITS-1:0]                           in_data,
    output logic                                      w_rd,
    output logic [$clog2((N_OUT/N_MAC)*(N_IN+1))-1:0] w_addr,
    input  logic [N_MAC*BITS-1:0]                     w_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [BITS-1:0]                           out_data,
    output logic [$clog2(N_OUT)-1:0]                  out_index,
    output logic                                      out_last,
    output logic                                      busy
);

    localparam int P    = N_OUT / N_MAC;
    localparam int PW   = (P > 1) ? $clog2(P) : 1;
    localparam int CW   = $clog2(N_IN + 2);
    localparam int PIXW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int AW   = $clog2(P * (N_IN + 1));
    localparam int OW   = $clog2(N_OUT);

    localparam logic [CW-1:0]   C_BIAS   = CW'(N_IN);
    localparam logic [CW-1:0]   C_STORE  = CW'(N_IN + 1);
    localparam logic [PW-1:0]   P_LAST   = PW'(P - 1);
    localparam logic [PIXW-1:0] PIX_LAST = PIXW'(N_IN - 1);
    localparam logic [OW-1:0]   IDX_LAST = OW'(N_OUT - 1);

    localparam logic signed [ACC_BITS-1:0] SAT_MAX = {{(ACC_BITS-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] SAT_MIN = {{(ACC_BITS-BITS+1){1'b1}}, {(BITS-1){1'b0}}};

    generate
        if ((N_OUT % N_MAC) != 0) begin : g_bad_mac
            $error("fc_layer_stream: N_MAC (%0d) must divide N_OUT (%0d)", N_MAC, N_OUT);
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t                       state_r, state_nxt_s;
    logic [PIXW-1:0]              cnt_r;
    logic [CW-1:0]                c_r, c_nxt_s;
    logic [PW-1:0]                p_r, p_nxt_s;
    logic [AW-1:0]                w_addr_r, w_addr_nxt_s;
    logic                         w_rd_r, in_ready_r, busy_r;
    logic                         out_valid_r, out_last_r;
    logic [BITS-1:0]              out_data_r;
    logic [OW-1:0]                out_index_r, out_idx_inc_s;

    logic [BITS-1:0]              pix_mem_r [N_IN];
    logic [BITS-1:0]              pix_q_r;
    logic signed [ACC_BITS-1:0]   acc_r      [N_MAC];
    logic signed [ACC_BITS-1:0]   mac_sum_s  [N_MAC];
    logic signed [ACC_BITS-1:0]   bias_sum_s [N_MAC];
    logic [2*BITS-1:0]            prod_s     [N_MAC];
    logic [BITS-1:0]              result_r     [N_OUT];
    logic [BITS-1:0]              result_nxt_s [N_OUT];

    logic                         load_fire_s, out_fire_s, step_store_s;

    assign in_ready  = in_ready_r;
    assign w_rd      = w_rd_r;
    assign w_addr    = w_addr_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_index = out_index_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

    assign load_fire_s   = (state_r == ST_LOAD) && in_valid && in_ready_r;
    assign out_fire_s    = (state_r == ST_OUTPUT) && out_valid_r && out_ready;
    assign step_store_s  = (state_r == ST_COMPUTE) && (c_r == C_STORE);
    assign out_idx_inc_s = out_index_r + OW'(1);

    // Scale down by FRAC (floor), clamp to the output range, optionally rectify.
    function automatic logic [BITS-1:0] sat_result(input logic signed [ACC_BITS-1:0] acc);
        logic signed [ACC_BITS-1:0] shifted;
        logic [BITS-1:0]            clamped;
        shifted = acc >>> FRAC;
        if (shifted > SAT_MAX) begin
            clamped = SAT_MAX[BITS-1:0];
        end else if (shifted < SAT_MIN) begin
            clamped = SAT_MIN[BITS-1:0];
        end else begin
            clamped = shifted[BITS-1:0];
        end
`ifdef FC_RELU_EN
        if (clamped[BITS-1]) begin
            clamped = {BITS{1'b0}};
        end else begin
            clamped = clamped;
        end
`endif
        return clamped;
    endfunction

    // Next-state logic for the LOAD / COMPUTE / OUTPUT sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_fire_s && (cnt_r == PIX_LAST)) state_nxt_s = ST_COMPUTE;
                else                                    state_nxt_s = ST_LOAD;
            end
            ST_COMPUTE: begin
                if (step_store_s && (p_r == P_LAST)) state_nxt_s = ST_OUTPUT;
                else                                 state_nxt_s = ST_COMPUTE;
            end
            ST_OUTPUT: begin
                if (out_fire_s && (out_index_r == IDX_LAST)) state_nxt_s = ST_LOAD;
                else                                         state_nxt_s = ST_OUTPUT;
            end
            default: state_nxt_s = ST_LOAD;
        endcase
    end

    // Step, pass and weight address for the coming cycle; the address holds over the store step.
    always_comb begin
        c_nxt_s      = {CW{1'b0}};
        p_nxt_s      = {PW{1'b0}};
        w_addr_nxt_s = {AW{1'b0}};
        if ((state_r == ST_COMPUTE) && (state_nxt_s == ST_COMPUTE)) begin
            if (step_store_s) begin
                c_nxt_s      = {CW{1'b0}};
                p_nxt_s      = p_r + PW'(1);
                w_addr_nxt_s = w_addr_r + AW'(1);
            end else begin
                c_nxt_s = c_r + CW'(1);
                p_nxt_s = p_r;
                if (c_r == C_BIAS) w_addr_nxt_s = w_addr_r;
                else               w_addr_nxt_s = w_addr_r + AW'(1);
            end
        end else begin
            c_nxt_s      = {CW{1'b0}};
            p_nxt_s      = {PW{1'b0}};
            w_addr_nxt_s = {AW{1'b0}};
        end
    end

    // Per-lane multiply-accumulate and bias-add paths, plus result-bank update on the store step.
    always_comb begin
        for (int j = 0; j < N_MAC; j++) begin
            prod_s[j]     = {{BITS{pix_q_r[BITS-1]}}, pix_q_r} *
                            {{BITS{w_data[j*BITS+BITS-1]}}, w_data[j*BITS +: BITS]};
            mac_sum_s[j]  = acc_r[j] + {{(ACC_BITS-2*BITS){prod_s[j][2*BITS-1]}}, prod_s[j]};
            bias_sum_s[j] = acc_r[j] +
                            ({{(ACC_BITS-BITS){w_data[j*BITS+BITS-1]}}, w_data[j*BITS +: BITS]} <<< FRAC);
        end
        for (int o = 0; o < N_OUT; o++) begin
            result_nxt_s[o] = result_r[o];
            if (step_store_s && (p_r == PW'(o / N_MAC))) begin
                result_nxt_s[o] = sat_result(bias_sum_s[o % N_MAC]);
            end else begin
                result_nxt_s[o] = result_r[o];
            end
        end
    end

    // Pixel RAM write port; contents need no reset since every image overwrites all entries.
    always_ff @(posedge clk) begin
        if (load_fire_s) pix_mem_r[cnt_r] <= in_data;
    end

    // Control state, counters and the registered handshake/weight-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_LOAD;
            cnt_r      <= {PIXW{1'b0}};
            c_r        <= {CW{1'b0}};
            p_r        <= {PW{1'b0}};
            w_addr_r   <= {AW{1'b0}};
            w_rd_r     <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            c_r        <= c_nxt_s;
            p_r        <= p_nxt_s;
            w_addr_r   <= w_addr_nxt_s;
            w_rd_r     <= (state_nxt_s == ST_COMPUTE) && (c_nxt_s <= C_BIAS);
            in_ready_r <= (state_nxt_s == ST_LOAD);
            busy_r     <= (state_nxt_s != ST_LOAD);
            if (load_fire_s) begin
                if (cnt_r == PIX_LAST) cnt_r <= {PIXW{1'b0}};
                else                   cnt_r <= cnt_r + PIXW'(1);
            end
        end
    end

    // Pixel read pipeline, accumulators (cleared at step 0) and the result bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_q_r <= {BITS{1'b0}};
            for (int j = 0; j < N_MAC; j++) acc_r[j] <= {ACC_BITS{1'b0}};
            for (int o = 0; o < N_OUT; o++) result_r[o] <= {BITS{1'b0}};
        end else begin
            if ((state_r == ST_COMPUTE) && (c_r < C_BIAS)) pix_q_r <= pix_mem_r[c_r[PIXW-1:0]];
            if (state_r == ST_COMPUTE) begin
                for (int j = 0; j < N_MAC; j++) begin
                    if (c_r == {CW{1'b0}})  acc_r[j] <= {ACC_BITS{1'b0}};
                    else if (c_r <= C_BIAS) acc_r[j] <= mac_sum_s[j];
                    else                    acc_r[j] <= acc_r[j];
                end
            end
            for (int o = 0; o < N_OUT; o++) result_r[o] <= result_nxt_s[o];
        end
    end

    // Output stream: first beat loads straight from the updated result bank, then advances on each accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_index_r <= {OW{1'b0}};
            out_data_r  <= {BITS{1'b0}};
            out_last_r  <= 1'b0;
        end else if ((state_r == ST_COMPUTE) && (state_nxt_s == ST_OUTPUT)) begin
            out_valid_r <= 1'b1;
            out_index_r <= {OW{1'b0}};
            out_data_r  <= result_nxt_s[0];
            out_last_r  <= (IDX_LAST == {OW{1'b0}});
        end else if (out_fire_s) begin
            if (out_last_r) begin
                out_valid_r <= 1'b0;
                out_index_r <= {OW{1'b0}};
                out_data_r  <= {BITS{1'b0}};
                out_last_r  <= 1'b0;
            end else begin
                out_index_r <= out_idx_inc_s;
                out_data_r  <= result_r[out_idx_inc_s];
                out_last_r  <= (out_idx_inc_s == IDX_LAST);
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Testbench for fc_layer_stream in the small configuration (4 inputs, 4 outputs, 2 lanes, Q8.8).
// A table of images, weights, biases and hand-computed results drives the run; expected beats
// are queued when an image is sent and compared as the DUT emits them.
module tb_fc_layer_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_ready, w_rd, out_valid, out_ready, out_last, busy;
    logic [15:0] in_data, out_data;
    logic [3:0]  w_addr;
    logic [31:0] w_data = 32'h0;
    logic [1:0]  out_index;

    fc_layer_stream #(.BITS(16), .FRAC(8), .N_IN(4), .N_OUT(4), .N_MAC(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] wmem [16];

    // Synchronous weight memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (w_rd) w_data <= wmem[w_addr];
    end

    typedef struct packed {
        logic [3:0][15:0]       img;
        logic [3:0][3:0][15:0]  w;    // w[o][k]
        logic [3:0][15:0]       b;
        logic [3:0][15:0]       exp;  // signed saturated result
    } vec_t;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] data;
        logic        last;
    } beat_t;

    vec_t  tbl [5];
    beat_t exp_q [$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef FC_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Sample at the falling edge; score any output handshake that the next rising edge completes.
    task automatic at_neg();
        beat_t bt;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: actual index %0d data %h required no beat", out_index, out_data);
            end else begin
                bt = exp_q.pop_front();
                chk("out_index", {62'd0, out_index}, {62'd0, bt.idx});
                chk("out_data", {48'd0, out_data}, {48'd0, bt.data});
                chk("out_last", {63'd0, out_last}, {63'd0, bt.last});
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input int r);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 5; k++) begin
                if (k < 4) wmem[p*5+k] = {tbl[r].w[p*2+1][k], tbl[r].w[p*2][k]};
                else       wmem[p*5+k] = {tbl[r].b[p*2+1], tbl[r].b[p*2]};
            end
        end
    endtask

    task automatic send_image(input int r, input bit hold, input bit push);
        bit    ok;
        beat_t bt;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = tbl[r].img[k];
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                at_neg();
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
                to_pos();
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: actual 0 required 1 (beat %0d)", k);
            end
            to_pos();
        end
        in_valid = hold;
        in_data  = hold ? 16'h5A5A : 16'h0000;
        if (push) begin
            for (int o = 0; o < 4; o++) begin
                bt.idx  = 2'(o);
                bt.data = relu(tbl[r].exp[o]);
                bt.last = (o == 3);
                exp_q.push_back(bt);
            end
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            at_neg();
            if ((exp_q.size() == 0) && in_ready && !out_valid) begin
                done = 1'b1;
                break;
            end
            to_pos();
        end
        to_pos();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: actual pending %0d required 0", exp_q.size());
        end
    endtask

    initial begin
        int lat, low, wrd;
        bit seen;

        // Test vectors: {image, weights, biases, expected signed results}.
        for (int r = 0; r < 5; r++) tbl[r] = '0;
        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 4; k++) begin
                tbl[0].w[o][k] = (o == k) ? 16'h0100 : 16'h0000;
                tbl[1].w[o][k] = 16'h7F00;
                tbl[2].w[o][k] = 16'h8100;
                tbl[3].w[o][k] = 16'h1234;
            end
            tbl[0].img[o] = 16'h0100; tbl[0].exp[o] = 16'h0100;
            tbl[1].img[o] = 16'h7F00; tbl[1].b[o] = 16'h7F00; tbl[1].exp[o] = 16'h7FFF;
            tbl[2].img[o] = 16'h7F00; tbl[2].b[o] = 16'h7F00; tbl[2].exp[o] = 16'h8000;
            tbl[3].b[o]   = 16'(o * 128);
            tbl[3].exp[o] = 16'(o * 128);
        end
        tbl[4].img[0] = 16'h0180; tbl[4].img[1] = 16'hFF80;
        tbl[4].img[2] = 16'h0040; tbl[4].img[3] = 16'h0200;
        tbl[4].w[0][0] = 16'h0100; tbl[4].w[1][1] = 16'h0100;
        tbl[4].w[2][1] = 16'h0001; tbl[4].w[3][3] = 16'h0001;
        tbl[4].b[3]    = 16'h0100;
        tbl[4].exp[0] = 16'h0180; tbl[4].exp[1] = 16'hFF80;
        tbl[4].exp[2] = 16'hFFFF; tbl[4].exp[3] = 16'h0102;

        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;

        // Reset state and in_ready rising on the first edge after release.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {37'd0, in_ready, w_rd, w_addr, out_valid, out_data, out_index, out_last, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("in_ready_at_release", {63'd0, in_ready}, 64'd0);
        to_pos();
        chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);

        // Identity image with in_valid held high: latency and busy window.
        load_weights(0);
        send_image(0, 1'b1, 1'b1);
        lat = 0; low = 0; wrd = 0; seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            at_neg();
            if (w_rd) wrd++;
            if (!seen && !out_valid) lat++;
            if (out_valid) seen = 1'b1;
            if (in_ready) begin
                in_valid = 1'b0;
                break;
            end
            low++;
            to_pos();
        end
        to_pos();
        chk("latency_first_valid", 64'(lat), 64'd12);
        chk("in_ready_low_cycles", 64'(low), 64'd16);
        chk("w_rd_cycles", 64'(wrd), 64'd10);
        chk("identity_drained", 64'(exp_q.size()), 64'd0);

        // Table-driven images: saturation both ways, bias only, mixed signs with floor rounding.
        for (int r = 1; r < 5; r++) begin
            load_weights(r);
            send_image(r, 1'b0, 1'b1);
            wait_idle();
        end

        // Backpressure: stall five cycles on index 1.
        load_weights(4);
        out_ready = 1'b0;
        send_image(4, 1'b0, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            at_neg();
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            to_pos();
        end
        chk("bp_out_valid_seen", {63'd0, seen}, 64'd1);
        chk("bp_first_index", {62'd0, out_index}, 64'd0);
        to_pos();
        out_ready = 1'b1;
        at_neg();
        to_pos();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_hold_index", {62'd0, out_index}, 64'd1);
            chk("bp_hold_data", {48'd0, out_data}, {48'd0, relu(tbl[4].exp[1])});
            to_pos();
        end
        out_ready = 1'b1;
        wait_idle();

        // Reset at pass 1 step 2, then a fresh image.
        load_weights(1);
        send_image(1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            at_neg();
            to_pos();
        end
        at_neg();
        chk("mid_w_addr", {60'd0, w_addr}, 64'd7);
        chk("mid_w_rd", {63'd0, w_rd}, 64'd1);
        chk("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("midreset_outputs", {37'd0, in_ready, w_rd, w_addr, out_valid, out_data, out_index, out_last, busy}, 64'd0);
        to_pos();
        at_neg();
        chk("midreset_outputs_held", {37'd0, in_ready, w_rd, w_addr, out_valid, out_data, out_index, out_last, busy}, 64'd0);
        reset = 1'b1;
        to_pos();
        chk("in_ready_after_midreset", {63'd0, in_ready}, 64'd1);
        load_weights(3);
        send_image(3, 1'b0, 1'b1);
        wait_idle();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
